// File: rtl/sr_ignition_pkg.sv
// Shared encodings, Q14 constants and the per-state phase-duration table
// for the ignition sequencer.
package sr_ignition_pkg;

  localparam logic [2:0] PH_BASELINE   = 3'd0;
  localparam logic [2:0] PH_P1         = 3'd1;
  localparam logic [2:0] PH_P2         = 3'd2;
  localparam logic [2:0] PH_P3         = 3'd3;
  localparam logic [2:0] PH_P4         = 3'd4;
  localparam logic [2:0] PH_P5         = 3'd5;
  localparam logic [2:0] PH_REFRACTORY = 3'd6;

  localparam logic [2:0] SEL_NORMAL      = 3'd0;
  localparam logic [2:0] SEL_ANESTHESIA  = 3'd1;
  localparam logic [2:0] SEL_PSYCHEDELIC = 3'd2;
  localparam logic [2:0] SEL_FLOW        = 3'd3;
  localparam logic [2:0] SEL_MEDITATION  = 3'd4;

  localparam logic signed [17:0] Q14_0P60 = 18'sd9830;
  localparam logic signed [17:0] Q14_0P75 = 18'sd12288;

  typedef struct packed {
    logic [15:0] p2;
    logic [15:0] p3;
    logic [15:0] p4;
    logic [15:0] p5;
    logic [15:0] p6;
    logic [15:0] refr;
  } dur_cfg_t;

  localparam dur_cfg_t DUR_NORMAL      = {16'd1400, 16'd1000, 16'd1000, 16'd3600, 16'd1600, 16'd4000};
  localparam dur_cfg_t DUR_ANESTHESIA  = {16'd2800, 16'd1600, 16'd600,  16'd2000, 16'd2400, 16'd8000};
  localparam dur_cfg_t DUR_PSYCHEDELIC = {16'd800,  16'd600,  16'd1600, 16'd6000, 16'd1200, 16'd2000};
  localparam dur_cfg_t DUR_FLOW        = {16'd1000, 16'd800,  16'd1400, 16'd4400, 16'd1400, 16'd3000};
  localparam dur_cfg_t DUR_MEDITATION  = {16'd2000, 16'd1200, 16'd2000, 16'd5200, 16'd2000, 16'd3000};

  // Unassigned select codes fall back to NORMAL.
  function automatic logic [2:0] norm_state(input logic [2:0] sel);
    logic [2:0] r;
    case (sel)
      SEL_NORMAL, SEL_ANESTHESIA, SEL_PSYCHEDELIC,
      SEL_FLOW, SEL_MEDITATION: r = sel;
      default:                  r = SEL_NORMAL;
    endcase
    return r;
  endfunction

  function automatic dur_cfg_t dur_lookup(input logic [2:0] st);
    dur_cfg_t r;
    case (st)
      SEL_ANESTHESIA:  r = DUR_ANESTHESIA;
      SEL_PSYCHEDELIC: r = DUR_PSYCHEDELIC;
      SEL_FLOW:        r = DUR_FLOW;
      SEL_MEDITATION:  r = DUR_MEDITATION;
      default:         r = DUR_NORMAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sr_trigger_debounce.sv
// Coherence/beta-quiet qualify compare plus consecutive-tick counter;
// done flags the tick on which the qualify streak reaches DEBOUNCE.
module sr_trigger_debounce
  import sr_ignition_pkg::*;
#(
  parameter int                      WIDTH    = 18,
  parameter logic signed [WIDTH-1:0] THRESH   = Q14_0P60,
  parameter int                      DEBOUNCE = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic                    active_i,
  input  logic signed [WIDTH-1:0] coherence_i,
  input  logic                    beta_quiet_raw_i,
  output logic                    qualify_o,
  output logic                    done_o
);

  logic [15:0] deb_cnt_q, deb_cnt_d;

  assign qualify_o = (coherence_i >= THRESH) && beta_quiet_raw_i;
  assign done_o    = qualify_o && (({1'b0, deb_cnt_q} + 17'd1) >= 17'(DEBOUNCE));

  // Count only while the sequencer is listening; any break clears the streak.
  always_comb begin
    deb_cnt_d = 16'd0;
    if (active_i && qualify_o) begin
      deb_cnt_d = (deb_cnt_q == 16'hFFFF) ? deb_cnt_q : deb_cnt_q + 16'd1;
    end else begin
      deb_cnt_d = 16'd0;
    end
  end

  // Counter register, advancing on ticks only.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q <= 16'd0;
    end else if (clk_en) begin
      deb_cnt_q <= deb_cnt_d;
    end
  end

endmodule

// File: rtl/sr_ignition_sequencer.sv
// Trigger qualification, forced-ignition arbitration and duration-table
// scheduling in front of the ignition controller.
module sr_ignition_sequencer
  import sr_ignition_pkg::*;
#(
  parameter int                      WIDTH        = 18,
  parameter int                      FRAC         = 14,
  parameter logic signed [WIDTH-1:0] COH_THRESH   = Q14_0P60,
  parameter int                      DEBOUNCE     = 40,
  parameter int                      FIRE_TIMEOUT = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic [2:0]              state_select,
  input  logic signed [WIDTH-1:0] coherence_in,
  input  logic                    beta_quiet_raw,
  input  logic                    force_req,
  input  logic [2:0]              ignition_phase,
  output logic signed [WIDTH-1:0] coherence_out,
  output logic                    beta_quiet,
  output logic [15:0]             phase2_dur,
  output logic [15:0]             phase3_dur,
  output logic [15:0]             phase4_dur,
  output logic [15:0]             phase5_dur,
  output logic [15:0]             phase6_dur,
  output logic [15:0]             refractory,
  output logic                    force_ack,
  output logic                    fire_fail,
  output logic                    cfg_pending,
  output logic [7:0]              event_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_FIRE = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam logic signed [WIDTH-1:0] FORCE_COH = WIDTH'((32'sd3 <<< FRAC) >>> 2);

  logic [1:0]              state_q, state_d;
  logic                    forced_q, forced_d;
  logic [15:0]             fire_cnt_q, fire_cnt_d;
  logic [7:0]              event_count_q, event_count_d;
  logic [2:0]              applied_q, applied_d;
  dur_cfg_t                dur_q;
  logic                    beta_quiet_q, force_ack_q, fire_fail_q, cfg_pending_q;
  logic                    force_ack_d, fire_fail_d;
  logic signed [WIDTH-1:0] coh_out_q;

  logic       phase_idle_s, qualify_s, deb_done_s, deb_active_s;
  logic [2:0] sel_norm_s;

  assign phase_idle_s = (ignition_phase == PH_BASELINE);
  assign sel_norm_s   = norm_state(state_select);
  assign deb_active_s = ((state_q == ST_IDLE) || (state_q == ST_ARM)) && phase_idle_s && !force_req;

  sr_trigger_debounce #(
    .WIDTH    (WIDTH),
    .THRESH   (COH_THRESH),
    .DEBOUNCE (DEBOUNCE)
  ) u_debounce (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .active_i         (deb_active_s),
    .coherence_i      (coherence_in),
    .beta_quiet_raw_i (beta_quiet_raw),
    .qualify_o        (qualify_s),
    .done_o           (deb_done_s)
  );

  // Sequencer next-state; an externally started controller takes us to RUN uncounted.
  always_comb begin
    state_d       = state_q;
    forced_d      = forced_q;
    fire_cnt_d    = fire_cnt_q;
    event_count_d = event_count_q;
    force_ack_d   = 1'b0;
    fire_fail_d   = 1'b0;
    case (state_q)
      ST_IDLE, ST_ARM: begin
        if (!phase_idle_s) begin
          state_d = ST_RUN;
        end else if (force_req) begin
          state_d    = ST_FIRE;
          forced_d   = 1'b1;
          fire_cnt_d = 16'd0;
        end else if (deb_done_s) begin
          state_d    = ST_FIRE;
          forced_d   = 1'b0;
          fire_cnt_d = 16'd0;
        end else if (qualify_s) begin
          state_d = ST_ARM;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FIRE: begin
        if (!phase_idle_s) begin
          state_d       = ST_RUN;
          event_count_d = (event_count_q == 8'hFF) ? 8'hFF : event_count_q + 8'd1;
          force_ack_d   = forced_q;
        end else if ((fire_cnt_q + 16'd1) >= 16'(FIRE_TIMEOUT)) begin
          state_d     = ST_IDLE;
          fire_fail_d = 1'b1;
        end else begin
          fire_cnt_d = fire_cnt_q + 16'd1;
        end
      end
      ST_RUN: begin
        if (phase_idle_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_q == ST_IDLE) begin
      applied_d = sel_norm_s;
    end else begin
      applied_d = applied_q;
    end
  end

  // State and output registers; pulses self-clear on the next clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      forced_q      <= 1'b0;
      fire_cnt_q    <= 16'd0;
      event_count_q <= 8'd0;
      applied_q     <= SEL_NORMAL;
      dur_q         <= DUR_NORMAL;
      beta_quiet_q  <= 1'b0;
      force_ack_q   <= 1'b0;
      fire_fail_q   <= 1'b0;
      cfg_pending_q <= 1'b0;
      coh_out_q     <= '0;
    end else begin
      force_ack_q <= 1'b0;
      fire_fail_q <= 1'b0;
      if (clk_en) begin
        state_q       <= state_d;
        forced_q      <= forced_d;
        fire_cnt_q    <= fire_cnt_d;
        event_count_q <= event_count_d;
        applied_q     <= applied_d;
        dur_q         <= dur_lookup(applied_d);
        force_ack_q   <= force_ack_d;
        fire_fail_q   <= fire_fail_d;
        cfg_pending_q <= (sel_norm_s != applied_d);
        beta_quiet_q  <= (state_d == ST_FIRE);
        coh_out_q     <= ((state_d == ST_FIRE) && forced_d) ? FORCE_COH : coherence_in;
      end
    end
  end

  assign coherence_out = coh_out_q;
  assign beta_quiet    = beta_quiet_q;
  assign phase2_dur    = dur_q.p2;
  assign phase3_dur    = dur_q.p3;
  assign phase4_dur    = dur_q.p4;
  assign phase5_dur    = dur_q.p5;
  assign phase6_dur    = dur_q.p6;
  assign refractory    = dur_q.refr;
  assign force_ack     = force_ack_q;
  assign fire_fail     = fire_fail_q;
  assign cfg_pending   = cfg_pending_q;
  assign event_count   = event_count_q;

endmodule

// File: tb/tb_sr_ignition_sequencer.sv
// Directed bench for sr_ignition_sequencer: a tick-level behavioural model
// checked every clk, plus hand-computed literal expectations.
module tb_sr_ignition_sequencer;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               clk_en = 1'b0;
  logic [2:0]         state_select = 3'd0;
  logic signed [17:0] coherence_in = 18'sd0;
  logic               beta_quiet_raw = 1'b0;
  logic               force_req = 1'b0;
  logic [2:0]         ignition_phase = 3'd0;
  logic signed [17:0] coherence_out;
  logic               beta_quiet;
  logic [15:0]        phase2_dur, phase3_dur, phase4_dur, phase5_dur, phase6_dur, refractory;
  logic               force_ack, fire_fail, cfg_pending;
  logic [7:0]         event_count;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  sr_ignition_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .clk_en         (clk_en),
    .state_select   (state_select),
    .coherence_in   (coherence_in),
    .beta_quiet_raw (beta_quiet_raw),
    .force_req      (force_req),
    .ignition_phase (ignition_phase),
    .coherence_out  (coherence_out),
    .beta_quiet     (beta_quiet),
    .phase2_dur     (phase2_dur),
    .phase3_dur     (phase3_dur),
    .phase4_dur     (phase4_dur),
    .phase5_dur     (phase5_dur),
    .phase6_dur     (phase6_dur),
    .refractory     (refractory),
    .force_ack      (force_ack),
    .fire_fail      (fire_fail),
    .cfg_pending    (cfg_pending),
    .event_count    (event_count)
  );

  always #4 clk = ~clk;

  task automatic cmp(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (one update per tick) ----------------
  int dur_tab [5][6] = '{
    '{1400, 1000, 1000, 3600, 1600, 4000},
    '{2800, 1600,  600, 2000, 2400, 8000},
    '{ 800,  600, 1600, 6000, 1200, 2000},
    '{1000,  800, 1400, 4400, 1400, 3000},
    '{2000, 1200, 2000, 5200, 2000, 3000}};

  // modes: 0 waiting, 1 counting streak, 2 firing, 3 controller running
  int m_mode = 0, m_streak = 0, m_age = 0, m_events = 0, m_applied = 0, m_sel = 0;
  bit m_forced = 0, m_q = 0, m_was_waiting = 0;
  bit m_bq = 0, m_ack = 0, m_fail = 0, m_pend = 0;
  logic signed [17:0] m_coh = 18'sd0;

  always @(posedge clk) begin
    m_ack  = 1'b0;
    m_fail = 1'b0;
    if (rst) begin
      m_mode = 0; m_streak = 0; m_age = 0; m_events = 0; m_applied = 0;
      m_forced = 0; m_bq = 0; m_pend = 0; m_coh = 18'sd0;
    end else if (clk_en) begin
      m_sel = (state_select > 3'd4) ? 0 : int'(state_select);
      m_q = (coherence_in >= 18'sd9830) && beta_quiet_raw;
      m_was_waiting = (m_mode == 0);
      if (m_mode <= 1) begin
        if (ignition_phase != 3'd0) begin
          m_mode = 3; m_streak = 0;
        end else if (force_req) begin
          m_mode = 2; m_forced = 1; m_age = 0; m_streak = 0;
        end else if (m_q) begin
          m_streak++;
          if (m_streak == 40) begin
            m_mode = 2; m_forced = 0; m_age = 0; m_streak = 0;
          end else m_mode = 1;
        end else begin
          m_mode = 0; m_streak = 0;
        end
      end else if (m_mode == 2) begin
        if (ignition_phase != 3'd0) begin
          m_mode = 3;
          if (m_events < 255) m_events++;
          m_ack = m_forced;
        end else begin
          m_age++;
          if (m_age == 8) begin
            m_mode = 0; m_fail = 1;
          end
        end
      end else if (ignition_phase == 3'd0) m_mode = 0;
      if (m_was_waiting) m_applied = m_sel;
      m_pend = (m_sel != m_applied);
      m_bq   = (m_mode == 2);
      m_coh  = (m_mode == 2 && m_forced) ? 18'sd12288 : coherence_in;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_on) begin
      cmp("beta_quiet", beta_quiet, m_bq);
      cmp("coherence_out", coherence_out, m_coh);
      cmp("force_ack", force_ack, m_ack);
      cmp("fire_fail", fire_fail, m_fail);
      cmp("cfg_pending", cfg_pending, m_pend);
      cmp("event_count", event_count, m_events);
      cmp("phase2_dur", phase2_dur, dur_tab[m_applied][0]);
      cmp("phase3_dur", phase3_dur, dur_tab[m_applied][1]);
      cmp("phase4_dur", phase4_dur, dur_tab[m_applied][2]);
      cmp("phase5_dur", phase5_dur, dur_tab[m_applied][3]);
      cmp("phase6_dur", phase6_dur, dur_tab[m_applied][4]);
      cmp("refractory", refractory, dur_tab[m_applied][5]);
    end
  end

  // One 4 kHz tick: three idle clks, then clk_en high for one clk.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      clk_en = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      clk_en = 1'b1;
      @(posedge clk); #1;
      clk_en = 1'b0;
    end
  endtask

  task automatic forced_ignition();
    force_req = 1'b1;
    step(1);
    ignition_phase = 3'd1;
    step(1);
    force_req = 1'b0;
    ignition_phase = 3'd0;
    step(1);
  endtask

  initial begin
    @(posedge clk); #1;
    chk_on = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    cmp("rst_p2", phase2_dur, 1400);
    cmp("rst_refr", refractory, 4000);
    cmp("rst_bq", beta_quiet, 0);
    cmp("rst_events", event_count, 0);
    cmp("rst_coh", coherence_out, 0);

    // natural trigger: 40 qualifying ticks
    coherence_in = 18'sd12288; beta_quiet_raw = 1'b1;
    step(39);
    cmp("nat_bq_39", beta_quiet, 0);
    step(1);
    cmp("nat_bq_40", beta_quiet, 1);
    cmp("nat_coh", coherence_out, 12288);
    ignition_phase = 3'd1;
    step(1);
    cmp("nat_events", event_count, 1);
    cmp("nat_bq_run", beta_quiet, 0);
    beta_quiet_raw = 1'b0; coherence_in = 18'sd0; ignition_phase = 3'd0;
    step(1);

    // streak broken at tick 39 restarts the count
    coherence_in = 18'sd12288; beta_quiet_raw = 1'b1;
    step(38);
    beta_quiet_raw = 1'b0;
    step(1);
    beta_quiet_raw = 1'b1;
    step(38);
    cmp("break_bq", beta_quiet, 0);
    beta_quiet_raw = 1'b0; coherence_in = 18'sd0;
    step(1);

    // forced ignition with ack
    force_req = 1'b1;
    step(1);
    cmp("frc_coh", coherence_out, 12288);
    cmp("frc_bq", beta_quiet, 1);
    ignition_phase = 3'd1;
    step(1);
    cmp("frc_ack", force_ack, 1);
    cmp("frc_events", event_count, 2);
    force_req = 1'b0;
    step(1);
    cmp("frc_ack_gone", force_ack, 0);
    ignition_phase = 3'd0;
    step(1);

    // forced ignition that times out
    force_req = 1'b1;
    step(8);
    cmp("to_fail_7", fire_fail, 0);
    cmp("to_bq_7", beta_quiet, 1);
    step(1);
    cmp("to_fail", fire_fail, 1);
    cmp("to_bq", beta_quiet, 0);
    force_req = 1'b0;
    step(1);
    cmp("to_events", event_count, 2);

    // config change held during RUN, phases 1..6 keep beta_quiet low
    ignition_phase = 3'd1;
    step(1);
    state_select = 3'd4;
    step(1);
    cmp("cfg_pend", cfg_pending, 1);
    cmp("cfg_hold_p2", phase2_dur, 1400);
    coherence_in = 18'sd12288; beta_quiet_raw = 1'b1;
    for (int p = 2; p <= 6; p++) begin
      ignition_phase = 3'(p);
      step(1);
      cmp("run_bq", beta_quiet, 0);
    end
    ignition_phase = 3'd0; beta_quiet_raw = 1'b0; coherence_in = 18'sd0;
    step(2);
    cmp("cfg_p2", phase2_dur, 2000);
    cmp("cfg_p5", phase5_dur, 5200);
    cmp("cfg_refr", refractory, 3000);
    cmp("cfg_pend_clr", cfg_pending, 0);
    cmp("ext_events", event_count, 2);

    // saturation: 254 more ignitions (256 in total)
    for (int k = 0; k < 254; k++) forced_ignition();
    cmp("sat_events", event_count, 255);

    // unassigned select maps to NORMAL
    state_select = 3'd7;
    step(1);
    cmp("sel7_p2", phase2_dur, 1400);
    cmp("sel7_refr", refractory, 4000);
    cmp("sel7_pend", cfg_pending, 0);

    // reset in the middle of FIRE
    force_req = 1'b1;
    step(1);
    cmp("mid_bq", beta_quiet, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("mid_rst_bq", beta_quiet, 0);
    cmp("mid_rst_events", event_count, 0);
    rst = 1'b0; force_req = 1'b0;
    step(2);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sr_ignition_sequencer.md
# sr_ignition_sequencer

Trigger-qualification and configuration scheduler placed directly in front of `sr_ignition_controller`. It selects the six phase-duration words for the current consciousness state and only updates them when no ignition is in progress. It debounces the coherence/beta-quiet trigger, and it arbitrates a software forced-ignition request against the natural trigger. The controller's `coherence_in`, `beta_quiet` and duration ports are driven by this block; the controller's `ignition_phase` is fed back into it.

## Interface
- `WIDTH`, 18: signed coherence word width
- `FRAC`, 14: fractional bits (Q14)
- `COH_THRESH`, 18'sd9830: natural-trigger coherence threshold (0.60)
- `DEBOUNCE`, 40: qualifying ticks before firing
- `FIRE_TIMEOUT`, 8: ticks to wait for the controller to leave BASELINE
- `clk`  in  1  system clock, 125 MHz
- `rst`  in  1  synchronous, active-high reset
- `clk_en`  in  1  4 kHz tick; all state advances only when `clk_en`=1
- `state_select`  in  3  consciousness state: 0 NORMAL, 1 ANESTHESIA, 2 PSYCHEDELIC, 3 FLOW, 4 MEDITATION; 5–7 map to NORMAL
- `coherence_in`  in  WIDTH signed  measured PLV
- `beta_quiet_raw`  in  1  undebounced beta-quiet flag
- `force_req`  in  1  forced-ignition request, level, held until ack
- `ignition_phase`  in  3  controller phase feedback (0 BASELINE … 6 REFRACTORY)
- `coherence_out`  out  WIDTH signed  to controller
- `beta_quiet`  out  1  qualified trigger to controller
- `phase2_dur`, `phase3_dur`, `phase4_dur`, `phase5_dur`, `phase6_dur`, `refractory`  out  16 each  to controller
- `force_ack`  out  1  one-`clk` pulse when a forced ignition starts
- `fire_fail`  out  1  one-`clk` pulse on timeout
- `cfg_pending`  out  1  `state_select` differs from the applied state
- `event_count`  out  8  ignitions started, saturating at 255

## Operation
- FSM states: IDLE, ARM, FIRE, RUN.
- **IDLE**
  - Requires `ignition_phase`=0.
  - If `force_req`=1 → FIRE (forced).
  - Else if qualify = (`coherence_in` ≥ `COH_THRESH` && `beta_quiet_raw`) → ARM with `deb_cnt`=1.
- **ARM**
  - Each tick with qualify: `deb_cnt`++. When it reaches `DEBOUNCE` → FIRE (natural).
  - Any tick without qualify → IDLE and `deb_cnt`=0.
  - `force_req` in ARM preempts → FIRE (forced).
- **FIRE**
  - Drives `beta_quiet`=1. Natural fire passes `coherence_out`=`coherence_in`; forced fire drives `coherence_out`=12288 (0.75).
  - When `ignition_phase`≠0 → RUN. On that transition: `event_count`++ (saturating), and `force_ack` pulses if the fire was forced.
  - After `FIRE_TIMEOUT` ticks with the phase still 0 → `fire_fail` pulse, then IDLE. `force_req` is not acked.
- **RUN**
  - `beta_quiet`=0; `coherence_out`=`coherence_in`.
  - When `ignition_phase` returns to 0 → IDLE. Refractory (phase 6) is part of RUN.
- Outside FIRE: `beta_quiet`=0 and `coherence_out`=`coherence_in`.
- **Config application**
  - Applied state latches from `state_select` only on a tick in IDLE. All six durations update together from the table on that same tick.
  - A `state_select` change in ARM, FIRE or RUN is held as `cfg_pending`=1 and applied on the first IDLE tick.
- **Duration table** (order: p2, p3, p4, p5, p6, refractory)
  - NORMAL: 1400, 1000, 1000, 3600, 1600, 4000
  - ANESTHESIA: 2800, 1600, 600, 2000, 2400, 8000
  - PSYCHEDELIC: 800, 600, 1600, 6000, 1200, 2000
  - FLOW: 1000, 800, 1400, 4400, 1400, 3000
  - MEDITATION: 2000, 1200, 2000, 5200, 2000, 3000
- `deb_cnt` is 16-bit unsigned. The threshold compare is signed.

## Timing
- Reset values:
  - FSM=IDLE, `deb_cnt`=0, `event_count`=0
  - `beta_quiet`=0, `force_ack`=0, `fire_fail`=0, `cfg_pending`=0
  - `coherence_out`=0
  - Durations = NORMAL, applied state = NORMAL
- Outputs are registered. Each changes on the `clk` edge of the tick that causes it.
- Natural path: the first qualifying tick plus `DEBOUNCE`−1 further ticks, then `beta_quiet` is high on the following tick.
- `force_ack` and `fire_fail` are single `clk` pulses, not held for a tick.
- Simultaneous `force_req` and qualify in IDLE: force wins.
- `rst` mid-FIRE drops `beta_quiet` the next `clk`.
- `ignition_phase`≠0 while in IDLE or ARM (controller started externally) → RUN, no count.

## Structure
- Package `sr_ignition_pkg`:
  - phase encodings, including BASELINE=0 and REFRACTORY=6
  - state_select encodings
  - the 5×6 duration table as localparams
  - Q14 constants (0.60, 0.75)
- Sub-module `sr_trigger_debounce`: the qualify compare plus `deb_cnt`, with a `done` output.
- FSM and config latching live in the top.

## Test plan
- Reset, `state_select`=0 → durations 1400/1000/1000/3600/1600/4000, `beta_quiet`=0, `event_count`=0.
- coherence 12288, `beta_quiet_raw`=1 held 40 ticks, phase fed back 1 → `beta_quiet` high once for ≤`FIRE_TIMEOUT` ticks, `event_count`=1. Break qualify at tick 39 → no fire.
- `force_req` with coherence 0 → `coherence_out`=12288, `beta_quiet`=1. Phase→1 gives one `force_ack` pulse. Phase held 0 for 8 ticks → `fire_fail` pulse, IDLE.
- `state_select`=4 during RUN → `cfg_pending`=1, durations unchanged. Phase→0 → durations 2000/1200/2000/5200/2000/3000 and `cfg_pending`=0.
- Phase sequence 1…6 with trigger conditions held → `beta_quiet` stays 0 until phase returns to 0.
- 256 ignitions → `event_count` saturates at 255. `state_select`=7 → NORMAL table.
